sensor_host_link: RTL and testbench
===================================

Name: sensor_host_link

Overview:
- Host-side counterpart of the temperature-sensor UART link. Runs on the host/FPGA end of the serial line, attached to a `uart_basic` instance there.
- Transmit path: programs the sensor's high and low hysteresis thresholds as command-tagged byte sequences.
- Receive path: reassembles the sensor's two-byte averaged count stream into 16-bit samples, with an inter-byte timeout.
- Sits between host logic (config request, sample consumer) and the host UART byte interface.

Parameters:
- CMD_HIGH, 8'h48, command byte that precedes the two high-threshold bytes.
- CMD_LOW, 8'h4C, command byte that precedes the two low-threshold bytes.
- TIMEOUT, 300, clk cycles allowed between the low and high byte of a sample (3 byte times at 10 clk/bit).
- TO_W, 16, width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  request to send both thresholds; sampled only when cfg_busy=0.
- cfg_high  in  16  high threshold; latched on an accepted cfg_start.
- cfg_low  in  16  low threshold; latched on an accepted cfg_start.
- cfg_busy  out  1  high from the cycle after an accepted cfg_start until the sequence completes.
- cfg_done  out  1  one-cycle pulse when the last byte has finished transmitting.
- tx_data  out  8  byte to the UART transmitter.
- tx_start  out  1  one-cycle transmit strobe to the UART.
- tx_busy  in  1  UART transmitter busy.
- rx_data  in  8  byte from the UART receiver.
- rx_ready  in  1  one-cycle strobe; rx_data is valid in that cycle.
- sample  out  16  last assembled sample, as {high byte, low byte}.
- sample_valid  out  1  one-cycle pulse when sample updates.
- timeout_err  out  1  one-cycle pulse when a partial sample is discarded.
- sample_cnt  out  8  count of valid samples, wraps 255 -> 0.

Behaviour:
- Reset: all outputs are 0 (cfg_busy, cfg_done, tx_start, tx_data, sample, sample_valid, timeout_err, sample_cnt).
  - TX FSM goes to T_IDLE; RX FSM goes to R_LO; the timeout counter clears.
  - A reset mid-transfer aborts it; no cfg_done is issued.
- TX FSM states:
  - T_IDLE: on cfg_start, latch thresholds, set byte index 0, go to T_LOAD.
  - T_LOAD: wait for tx_busy=0. Then drive tx_data and assert tx_start for exactly one cycle, and go to T_ACK.
  - T_ACK: wait for tx_busy=1, then go to T_DONE.
  - T_DONE: wait for tx_busy=0.
    - If index = 5: pulse cfg_done, go to T_IDLE.
    - Otherwise: increment index, go to T_LOAD.
- Byte order by index: 0 CMD_HIGH, 1 high[7:0], 2 high[15:8], 3 CMD_LOW, 4 low[7:0], 5 low[15:8]. Low byte goes first, matching the sensor's right-shifting threshold registers.
- cfg_busy = (state != T_IDLE). A cfg_start while busy is ignored, not queued. The latched thresholds are immune to input changes mid-sequence.
- tx_data holds its value from the tx_start cycle until the next load.
- RX FSM states:
  - R_LO: on rx_ready, store the byte as lo, clear the counter, go to R_HI.
  - R_HI:
    - On rx_ready: on the next cycle, sample = {rx_data, lo}, sample_valid=1, sample_cnt+1. Return to R_LO.
    - Otherwise the counter increments. When it reaches TIMEOUT-1 with no rx_ready: pulse timeout_err on the next cycle, discard lo, return to R_LO.
- Simultaneous events:
  - rx_ready in the same cycle as timeout expiry: the byte wins and is treated as the high byte; no timeout_err.
  - RX and TX paths are fully independent; traffic on one never stalls the other.
- Latency: sample_valid is asserted 1 cycle after the rx_ready of the high byte. cfg_done is asserted 1 cycle after tx_busy falls on the last byte.

Decomposition:
- Package sensor_link_pkg holds:
  - the default command constants CMD_HIGH and CMD_LOW;
  - the TX state encoding (T_IDLE, T_LOAD, T_ACK, T_DONE);
  - the RX state encoding (R_LO, R_HI);
  - the byte-index width (3).
- Sub-module sample_assembler holds the RX FSM, timeout counter and sample_cnt. The top level holds the TX FSM and instantiates sample_assembler.

Test Plan:
- Config sequence: cfg_high=16'h1234, cfg_low=16'h0ABC, one cfg_start pulse; UART model holds busy for 100 cycles per byte -> tx_data sequence 48,34,12,4C,BC,0A, exactly six tx_start pulses, one cfg_done, cfg_busy low afterwards.
- Busy rejection: a second cfg_start with different values during the sequence -> ignored; bytes sent still match the first request.
- Sample assembly: rx bytes 0x78 then 0x56, 100 cycles apart -> sample=16'h5678, one sample_valid pulse 1 cycle after the second rx_ready, sample_cnt=1.
- Timeout: one rx byte 0x11, then silence for 300 cycles -> timeout_err pulse, no sample_valid. Next pair 0x22, 0x33 -> sample=16'h3322.
- Boundary: second byte arrives exactly on the expiry cycle -> sample accepted, no timeout_err. After 256 samples -> sample_cnt wraps to 0.
- Reset mid-operation: rst asserted at index 3 of a config and during R_HI -> all outputs 0. A new cfg_start then restarts from CMD_HIGH.

Source files
------------

// File: rtl/sensor_link_pkg.sv
// -----------------------------------------------------------------------------
// sensor_link_pkg
// Shared definitions for the host side of the temperature-sensor UART link:
// default command bytes, TX/RX state encodings and the byte-index width.
// -----------------------------------------------------------------------------
package sensor_link_pkg;

   // Command bytes that precede each two-byte threshold on the wire
   localparam logic [7:0] CMD_HIGH = 8'h48;
   localparam logic [7:0] CMD_LOW  = 8'h4C;

   // Six bytes per configuration sequence, indexed 0..5
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_LOAD = 2'd1,
      T_ACK  = 2'd2,
      T_DONE = 2'd3
   } tx_state_t;

   typedef enum logic {
      R_LO = 1'b0,
      R_HI = 1'b1
   } rx_state_t;

endpackage

// File: rtl/sample_assembler.sv
// -----------------------------------------------------------------------------
// sample_assembler
// Rebuilds 16-bit samples from the sensor's low-byte-first byte stream.
// A partial sample is dropped if the high byte does not arrive within
// TIMEOUT cycles of the low byte.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rx_data       byte from the UART receiver
//   rx_ready      one-cycle strobe, rx_data valid
//   sample        last assembled sample {high byte, low byte}
//   sample_valid  one-cycle pulse when sample updates
//   timeout_err   one-cycle pulse when a partial sample is discarded
//   sample_cnt    count of valid samples, wraps 255 -> 0
// -----------------------------------------------------------------------------
module sample_assembler #(
   parameter int TIMEOUT = 300,
   parameter int TO_W    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic [15:0] sample,
   output logic        sample_valid,
   output logic        timeout_err,
   output logic [7:0]  sample_cnt
);
   import sensor_link_pkg::*;

   // Counter value on the last cycle a high byte is still accepted
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   rx_state_t       state, state_nxt;
   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
   logic [7:0]      lo_byte, lo_byte_nxt;
   logic [15:0]     sample_nxt;
   logic            valid_nxt;
   logic            to_err_nxt;
   logic [7:0]      cnt_nxt;

   always_comb begin
      state_nxt   = state;
      to_cnt_nxt  = to_cnt;
      lo_byte_nxt = lo_byte;
      sample_nxt  = sample;
      valid_nxt   = 1'b0;
      to_err_nxt  = 1'b0;
      cnt_nxt     = sample_cnt;
      if (state == R_LO) begin
         if (rx_ready) begin
            lo_byte_nxt = rx_data;
            to_cnt_nxt  = '0;
            state_nxt   = R_HI;
         end
      end else begin
         // A byte on the expiry cycle still completes the sample
         if (rx_ready) begin
            sample_nxt = {rx_data, lo_byte};
            valid_nxt  = 1'b1;
            cnt_nxt    = sample_cnt + 8'd1;
            state_nxt  = R_LO;
         end else if (to_cnt == TO_LAST) begin
            to_err_nxt = 1'b1;
            to_cnt_nxt = '0;
            state_nxt  = R_LO;
         end else begin
            to_cnt_nxt = to_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= R_LO;
         to_cnt       <= '0;
         lo_byte      <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
         timeout_err  <= 1'b0;
         sample_cnt   <= '0;
      end else begin
         state        <= state_nxt;
         to_cnt       <= to_cnt_nxt;
         lo_byte      <= lo_byte_nxt;
         sample       <= sample_nxt;
         sample_valid <= valid_nxt;
         timeout_err  <= to_err_nxt;
         sample_cnt   <= cnt_nxt;
      end
   end

endmodule

// File: rtl/sensor_host_link.sv
// -----------------------------------------------------------------------------
// sensor_host_link
// Host-side end of the temperature-sensor UART link. The TX path sends the
// high and low hysteresis thresholds as command-tagged byte sequences; the RX
// path (sample_assembler) rebuilds the sensor's two-byte sample stream.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_start           request to send both thresholds (ignored while busy)
//   cfg_high, cfg_low   thresholds, latched on an accepted cfg_start
//   cfg_busy            configuration sequence in progress
//   cfg_done            one-cycle pulse after the last byte has gone out
//   tx_data, tx_start   byte and one-cycle strobe to the UART transmitter
//   tx_busy             UART transmitter busy
//   rx_data, rx_ready   byte and one-cycle strobe from the UART receiver
//   sample, sample_valid, timeout_err, sample_cnt   see sample_assembler
// -----------------------------------------------------------------------------
module sensor_host_link #(
   parameter logic [7:0] CMD_HIGH = sensor_link_pkg::CMD_HIGH,
   parameter logic [7:0] CMD_LOW  = sensor_link_pkg::CMD_LOW,
   parameter int         TIMEOUT  = 300,
   parameter int         TO_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   input  logic [15:0] cfg_high,
   input  logic [15:0] cfg_low,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic [15:0] sample,
   output logic        sample_valid,
   output logic        timeout_err,
   output logic [7:0]  sample_cnt
);
   import sensor_link_pkg::T_IDLE;
   import sensor_link_pkg::T_LOAD;
   import sensor_link_pkg::T_ACK;
   import sensor_link_pkg::T_DONE;
   import sensor_link_pkg::tx_state_t;
   import sensor_link_pkg::IDX_W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);

   tx_state_t        tx_state, tx_state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [15:0]      high_q, high_nxt;
   logic [15:0]      low_q, low_nxt;
   logic [7:0]       tx_data_nxt;
   logic             tx_start_nxt;
   logic             cfg_done_nxt;

   // Each threshold goes out low byte first, matching the sensor's
   // right-shifting threshold registers.
   function automatic logic [7:0] tx_byte(input logic [IDX_W-1:0] i,
                                          input logic [15:0]      hi,
                                          input logic [15:0]      lo);
      case (i)
         3'd0:    return CMD_HIGH;
         3'd1:    return hi[7:0];
         3'd2:    return hi[15:8];
         3'd3:    return CMD_LOW;
         3'd4:    return lo[7:0];
         default: return lo[15:8];
      endcase
   endfunction

   assign cfg_busy = (tx_state != T_IDLE);

   always_comb begin
      tx_state_nxt = tx_state;
      idx_nxt      = idx;
      high_nxt     = high_q;
      low_nxt      = low_q;
      tx_data_nxt  = tx_data;
      tx_start_nxt = 1'b0;
      cfg_done_nxt = 1'b0;
      case (tx_state)
         T_IDLE: begin
            if (cfg_start) begin
               high_nxt     = cfg_high;
               low_nxt      = cfg_low;
               idx_nxt      = '0;
               tx_state_nxt = T_LOAD;
            end
         end
         T_LOAD: begin
            if (!tx_busy) begin
               tx_data_nxt  = tx_byte(idx, high_q, low_q);
               tx_start_nxt = 1'b1;
               tx_state_nxt = T_ACK;
            end
         end
         // Wait for the UART to acknowledge the strobe before watching
         // for the end of the byte, so a stale idle tx_busy is not mistaken
         // for completion.
         T_ACK: begin
            if (tx_busy) tx_state_nxt = T_DONE;
         end
         T_DONE: begin
            if (!tx_busy) begin
               if (idx == LAST_IDX) begin
                  cfg_done_nxt = 1'b1;
                  tx_state_nxt = T_IDLE;
               end else begin
                  idx_nxt      = idx + IDX_W'(1);
                  tx_state_nxt = T_LOAD;
               end
            end
         end
         default: tx_state_nxt = T_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= T_IDLE;
         idx      <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         cfg_done <= 1'b0;
      end else begin
         tx_state <= tx_state_nxt;
         idx      <= idx_nxt;
         tx_data  <= tx_data_nxt;
         tx_start <= tx_start_nxt;
         cfg_done <= cfg_done_nxt;
      end
   end

   // Threshold holding registers only change on an accepted request
   always_ff @(posedge clk) begin
      high_q <= high_nxt;
      low_q  <= low_nxt;
   end

   sample_assembler #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_sample_assembler (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .sample       (sample),
      .sample_valid (sample_valid),
      .timeout_err  (timeout_err),
      .sample_cnt   (sample_cnt)
   );

endmodule

// File: tb/tb_sensor_host_link.sv
// -----------------------------------------------------------------------------
// tb_sensor_host_link
// Directed bench for sensor_host_link with a behavioural UART transmitter and
// scoreboard queues for transmitted bytes and assembled samples.
// -----------------------------------------------------------------------------
module tb_sensor_host_link;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start;
   logic [15:0] cfg_high;
   logic [15:0] cfg_low;
   logic        cfg_busy;
   logic        cfg_done;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [15:0] sample;
   logic        sample_valid;
   logic        timeout_err;
   logic [7:0]  sample_cnt;

   always #5 clk = ~clk;

   sensor_host_link dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_start    (cfg_start),
      .cfg_high     (cfg_high),
      .cfg_low      (cfg_low),
      .cfg_busy     (cfg_busy),
      .cfg_done     (cfg_done),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_busy      (tx_busy),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .sample       (sample),
      .sample_valid (sample_valid),
      .timeout_err  (timeout_err),
      .sample_cnt   (sample_cnt)
   );

   typedef struct packed {
      logic [15:0] s;
      logic [7:0]  c;
   } samp_t;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  tx_q[$];
   samp_t       rx_q[$];
   int          n_tx = 0;
   int          n_done = 0;
   int          n_valid = 0;
   int          cyc = 0;
   int          last_fall = -10;
   int          uart_cnt = 0;
   logic [7:0]  exp_cnt = 8'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // UART transmitter model: busy for 100 cycles per accepted strobe
   always @(negedge clk) begin
      if (rst) begin
         uart_cnt = 0;
         tx_busy  = 1'b0;
      end else if (uart_cnt != 0) begin
         uart_cnt--;
         if (uart_cnt == 0) begin
            tx_busy   = 1'b0;
            last_fall = cyc;
         end
      end else if (tx_start) begin
         tx_busy  = 1'b1;
         uart_cnt = 100;
      end
   end

   // Output monitor: pops scoreboards as the DUT produces results
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_start) begin
            n_tx++;
            chk("tx_expected", 32'(tx_q.size() > 0), 32'd1);
            if (tx_q.size() > 0) chk("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
         end
         if (cfg_done) begin
            n_done++;
            chk("done_latency", cyc, last_fall + 1);
         end
         if (sample_valid) begin
            samp_t e;
            n_valid++;
            chk("sample_expected", 32'(rx_q.size() > 0), 32'd1);
            if (rx_q.size() > 0) begin
               e = rx_q.pop_front();
               chk("sample_value", 32'(sample), 32'(e.s));
               chk("sample_cnt", 32'(sample_cnt), 32'(e.c));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, {26'd0, cfg_busy, cfg_done, tx_start, sample_valid, timeout_err, 1'b0}, 32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({tag, "_sample"}, 32'(sample), 32'd0);
      chk({tag, "_cnt"}, 32'(sample_cnt), 32'd0);
   endtask

   task automatic push_cfg(input logic [15:0] hi, input logic [15:0] lo);
      tx_q.push_back(8'h48);
      tx_q.push_back(hi[7:0]);
      tx_q.push_back(hi[15:8]);
      tx_q.push_back(8'h4C);
      tx_q.push_back(lo[7:0]);
      tx_q.push_back(lo[15:8]);
   endtask

   task automatic start_cfg(input logic [15:0] hi, input logic [15:0] lo);
      cfg_high  = hi;
      cfg_low   = lo;
      cfg_start = 1'b1;
      tick(1);
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 3000 && n_done < target; i++) tick(1);
      chk("cfg_done_count", n_done, target);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   // Low byte, gap idle cycles, then high byte; expectation queued first
   task automatic rx_pair(input logic [7:0] lo, input logic [7:0] hi, input int gap);
      rx_byte(lo);
      tick(gap);
      exp_cnt = exp_cnt + 8'd1;
      rx_q.push_back({hi, lo, exp_cnt});
      rx_byte(hi);
   endtask

   initial begin
      int d0;
      int v0;
      int t0;
      rst = 1'b1; cfg_start = 1'b0; cfg_high = '0; cfg_low = '0;
      rx_data = '0; rx_ready = 1'b0; tx_busy = 1'b0;
      tick(3);
      check_zero("reset");
      rst = 1'b0;
      tick(1);

      // Configuration sequence with a rejected second request
      push_cfg(16'h1234, 16'h0ABC);
      start_cfg(16'h1234, 16'h0ABC);
      chk("busy_after_start", 32'(cfg_busy), 32'd1);
      tick(150);
      chk("busy_mid_seq", 32'(cfg_busy), 32'd1);
      start_cfg(16'hFFFF, 16'h5555);
      wait_done(1);
      tick(2);
      chk("tx_count", n_tx, 6);
      chk("busy_after_done", 32'(cfg_busy), 32'd0);
      chk("tx_data_hold", 32'(tx_data), 32'h0A);
      chk("tx_queue_empty", tx_q.size(), 0);

      // Sample assembly, 100 cycles between bytes
      rx_pair(8'h78, 8'h56, 99);
      chk("valid_latency", 32'(sample_valid), 32'd1);
      tick(1);
      chk("valid_single", 32'(sample_valid), 32'd0);

      // Timeout: lone byte, 300 silent cycles
      v0 = n_valid;
      rx_byte(8'h11);
      tick(299);
      chk("no_early_timeout", 32'(timeout_err), 32'd0);
      tick(1);
      chk("timeout_pulse", 32'(timeout_err), 32'd1);
      tick(1);
      chk("timeout_single", 32'(timeout_err), 32'd0);
      chk("no_valid_on_timeout", n_valid, v0);
      rx_pair(8'h22, 8'h33, 5);
      tick(1);

      // High byte arrives on the expiry cycle
      rx_pair(8'hAA, 8'hBB, 299);
      chk("boundary_valid", 32'(sample_valid), 32'd1);
      chk("boundary_no_to", 32'(timeout_err), 32'd0);
      tick(1);
      chk("boundary_no_to_late", 32'(timeout_err), 32'd0);

      // Wrap sample_cnt to 0 after 256 samples
      for (int i = 0; i < 253; i++) rx_pair(8'(i), 8'(255 - i), 1);
      tick(1);
      chk("cnt_wrap", 32'(sample_cnt), 32'd0);
      chk("rx_queue_empty", rx_q.size(), 0);
      rx_pair(8'h01, 8'h02, 1);
      tick(1);

      // Reset in the middle of a config (index 3) and in R_HI
      d0 = n_done;
      push_cfg(16'hBEEF, 16'h1357);
      start_cfg(16'hBEEF, 16'h1357);
      for (int i = 0; i < 2000 && n_tx < 10; i++) tick(1);
      chk("reached_index3", n_tx, 10);
      rx_byte(8'h44);
      rst = 1'b1;
      tick(2);
      check_zero("midreset");
      rst = 1'b0;
      tx_q.delete();
      tick(5);
      chk("no_done_on_reset", n_done, d0);

      // RX restarted in R_LO: first byte is a low byte
      v0 = n_valid;
      exp_cnt = 8'd0;
      rx_byte(8'h66);
      tick(20);
      chk("no_pair_across_reset", n_valid, v0);
      exp_cnt = exp_cnt + 8'd1;
      rx_q.push_back({8'h77, 8'h66, exp_cnt});
      rx_byte(8'h77);
      tick(1);

      // New config restarts from CMD_HIGH
      t0 = n_tx;
      push_cfg(16'hCAFE, 16'h0102);
      start_cfg(16'hCAFE, 16'h0102);
      wait_done(d0 + 1);
      tick(2);
      chk("restart_tx_count", n_tx - t0, 6);
      chk("restart_queue_empty", tx_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
